// File: rtl/button_input_capture.sv
// rtl/button_input_capture.sv - push-button sync, debounce, sticky press/release flags and IRQ
module button_input_capture #(
  parameter int CHANNELS          = 4,
  parameter int DEBOUNCE_CYCLES   = 1000,
  parameter int ACTIVE_LOW_INPUTS = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [CHANNELS-1:0]     i_buttons,
  input  logic [2*CHANNELS-1:0]   i_irq_enable,
  input  logic                    i_clear_valid,
  input  logic [2*CHANNELS-1:0]   i_clear_mask,
  input  logic                    i_clear_overrun,
  output logic [CHANNELS-1:0]     o_stable,
  output logic [CHANNELS-1:0]     o_press_flags,
  output logic [CHANNELS-1:0]     o_release_flags,
  output logic                    o_overrun,
  output logic                    o_irq
);

  localparam int FW = 2 * CHANNELS;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CHANNELS-1:0] w_pin_pressed;
  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;
  logic [CHANNELS-1:0] r_stable;
  logic [CHANNELS-1:0] r_press;
  logic [CHANNELS-1:0] r_release;
  logic                r_overrun;
  logic                r_irq;

  logic [CHANNELS-1:0] w_change;
  logic [CHANNELS-1:0] w_rise;
  logic [CHANNELS-1:0] w_fall;
  logic [FW-1:0]       w_flags;
  logic [FW-1:0]       w_set;
  logic [FW-1:0]       w_clr;
  logic [FW-1:0]       w_flags_next;
  logic                w_ovr_set;
  logic                w_ovr_clr;

  // Normalise polarity before synchronising so that reset value 0 means not pressed.
  generate
    if (ACTIVE_LOW_INPUTS != 0) begin : g_inv
      assign w_pin_pressed = ~i_buttons;
    end else begin : g_noinv
      assign w_pin_pressed = i_buttons;
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_pin_pressed;
      r_sync2 <= r_sync1;
    end
  end

  genvar g;
  generate
    for (g = 0; g < CHANNELS; g++) begin : g_ch
      logic [CW-1:0] r_cnt;

      assign w_change[g] = (r_sync2[g] != r_stable[g]) && (r_cnt == CNT_MAX);

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_cnt <= '0;
        end else if ((r_sync2[g] == r_stable[g]) || (r_cnt == CNT_MAX)) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  endgenerate

  assign w_rise  = w_change & r_sync2;
  assign w_fall  = w_change & ~r_sync2;
  assign w_flags = {r_release, r_press};
  assign w_set   = {w_fall, w_rise};
  assign w_clr   = i_clear_valid ? i_clear_mask : '0;

  // Set wins over a same-edge clear, so a clear never swallows a fresh event.
  assign w_flags_next = (w_flags & ~w_clr) | w_set;
  assign w_ovr_set    = |(w_set & w_flags & ~w_clr);
  assign w_ovr_clr    = i_clear_valid & i_clear_overrun;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stable  <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_overrun <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_stable  <= r_stable ^ w_change;
      r_press   <= w_flags_next[CHANNELS-1:0];
      r_release <= w_flags_next[FW-1:CHANNELS];
      r_overrun <= (r_overrun & ~w_ovr_clr) | w_ovr_set;
      r_irq     <= |(w_flags & i_irq_enable);
    end
  end

  assign o_stable        = r_stable;
  assign o_press_flags   = r_press;
  assign o_release_flags = r_release;
  assign o_overrun       = r_overrun;
  assign o_irq           = r_irq;

endmodule

// File: tb/tb_button_input_capture.sv
// tb/tb_button_input_capture.sv - vector table with scoreboard queue for button_input_capture
module tb_button_input_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] buttons;
  logic [7:0] irq_enable;
  logic       clear_valid;
  logic [7:0] clear_mask;
  logic       clear_overrun;
  logic [3:0] stable;
  logic [3:0] press_flags;
  logic [3:0] release_flags;
  logic       overrun;
  logic       irq;

  button_input_capture #(
    .CHANNELS(4),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW_INPUTS(1)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_buttons(buttons),
    .i_irq_enable(irq_enable),
    .i_clear_valid(clear_valid),
    .i_clear_mask(clear_mask),
    .i_clear_overrun(clear_overrun),
    .o_stable(stable),
    .o_press_flags(press_flags),
    .o_release_flags(release_flags),
    .o_overrun(overrun),
    .o_irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] btn;
    logic       cv;
    logic [7:0] mask;
    logic       cov;
    int         cyc;
    logic [3:0] s;
    logic [3:0] p;
    logic [3:0] r;
    logic       o;
    logic       i;
  } vec_t;

  vec_t        tbl[$];
  logic [13:0] sb[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          n_phase_a;

  task automatic add(input logic [3:0] btn, input logic cv, input logic [7:0] mask,
                     input logic cov, input int cyc, input logic [3:0] s,
                     input logic [3:0] p, input logic [3:0] r, input logic o, input logic i);
    vec_t v;
    v.btn = btn; v.cv = cv; v.mask = mask; v.cov = cov; v.cyc = cyc;
    v.s = s; v.p = p; v.r = r; v.o = o; v.i = i;
    tbl.push_back(v);
  endtask

  function automatic logic [13:0] outs();
    return {stable, press_flags, release_flags, overrun, irq};
  endfunction

  task automatic check(input string name, input logic [13:0] want);
    logic [13:0] got;
    got = outs();
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got s=%h p=%h r=%h o=%b i=%b, want s=%h p=%h r=%h o=%b i=%b",
               name, got[13:10], got[9:6], got[5:2], got[1], got[0],
               want[13:10], want[9:6], want[5:2], want[1], want[0]);
    end
  endtask

  // Inputs are driven 1 time unit after a rising edge; the clear strobe lasts one edge only.
  task automatic run_vec(input int idx);
    vec_t v;
    v = tbl[idx];
    sb.push_back({v.s, v.p, v.r, v.o, v.i});
    buttons       = v.btn;
    clear_valid   = v.cv;
    clear_mask    = v.mask;
    clear_overrun = v.cov;
    for (int c = 0; c < v.cyc; c++) begin
      @(posedge clk);
      #1;
      clear_valid   = 1'b0;
      clear_mask    = 8'h00;
      clear_overrun = 1'b0;
    end
    check($sformatf("vec%0d", idx), sb.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    buttons       = 4'hF;
    irq_enable    = 8'h0F;
    clear_valid   = 1'b0;
    clear_mask    = 8'h00;
    clear_overrun = 1'b0;

    // clean press / release of ch0, then clears
    add(4'hF, 0, 8'h00, 0, 2, 4'h0, 4'h0, 4'h0, 0, 0);
    add(4'hE, 0, 8'h00, 0, 5, 4'h0, 4'h0, 4'h0, 0, 0);
    add(4'hE, 0, 8'h00, 0, 1, 4'h1, 4'h1, 4'h0, 0, 0);
    add(4'hE, 0, 8'h00, 0, 1, 4'h1, 4'h1, 4'h0, 0, 1);
    add(4'hF, 0, 8'h00, 0, 5, 4'h1, 4'h1, 4'h0, 0, 1);
    add(4'hF, 0, 8'h00, 0, 1, 4'h0, 4'h1, 4'h1, 0, 1);
    add(4'hF, 0, 8'h00, 0, 1, 4'h0, 4'h1, 4'h1, 0, 1);
    add(4'hF, 1, 8'h01, 0, 1, 4'h0, 4'h0, 4'h1, 0, 1);
    add(4'hF, 0, 8'h00, 0, 1, 4'h0, 4'h0, 4'h1, 0, 0);
    add(4'hF, 1, 8'h10, 0, 1, 4'h0, 4'h0, 4'h0, 0, 0);
    // bounce on ch1: 3-cycle toggles never reach the 4-cycle threshold
    for (int k = 0; k < 10; k++)
      add((k % 2 == 0) ? 4'hD : 4'hF, 0, 8'h00, 0, 3, 4'h0, 4'h0, 4'h0, 0, 0);
    add(4'hF, 0, 8'h00, 0, 6, 4'h0, 4'h0, 4'h0, 0, 0);
    // clear on the exact press edge: set wins
    add(4'hE, 0, 8'h00, 0, 5, 4'h0, 4'h0, 4'h0, 0, 0);
    add(4'hE, 1, 8'h01, 0, 1, 4'h1, 4'h1, 4'h0, 0, 0);
    add(4'hE, 0, 8'h00, 0, 1, 4'h1, 4'h1, 4'h0, 0, 1);
    add(4'hE, 1, 8'h01, 0, 1, 4'h1, 4'h0, 4'h0, 0, 1);
    add(4'hE, 0, 8'h00, 0, 1, 4'h1, 4'h0, 4'h0, 0, 0);
    add(4'hF, 0, 8'h00, 0, 6, 4'h0, 4'h0, 4'h1, 0, 0);
    add(4'hF, 1, 8'h10, 0, 1, 4'h0, 4'h0, 4'h0, 0, 0);
    // overrun on ch2
    add(4'hB, 0, 8'h00, 0, 6, 4'h4, 4'h4, 4'h0, 0, 0);
    add(4'hB, 0, 8'h00, 0, 1, 4'h4, 4'h4, 4'h0, 0, 1);
    add(4'hF, 0, 8'h00, 0, 6, 4'h0, 4'h4, 4'h4, 0, 1);
    add(4'hB, 0, 8'h00, 0, 5, 4'h0, 4'h4, 4'h4, 0, 1);
    add(4'hB, 0, 8'h00, 0, 1, 4'h4, 4'h4, 4'h4, 1, 1);
    add(4'hB, 1, 8'h04, 1, 1, 4'h4, 4'h0, 4'h4, 0, 1);
    add(4'hB, 0, 8'h00, 0, 1, 4'h4, 4'h0, 4'h4, 0, 0);
    add(4'hF, 1, 8'h40, 0, 6, 4'h0, 4'h0, 4'h4, 0, 0);
    add(4'hF, 1, 8'h40, 0, 1, 4'h0, 4'h0, 4'h0, 0, 0);
    // all channels together, then ch3 released to debounce count 2
    add(4'h0, 0, 8'h00, 0, 5, 4'h0, 4'h0, 4'h0, 0, 0);
    add(4'h0, 0, 8'h00, 0, 1, 4'hF, 4'hF, 4'h0, 0, 0);
    add(4'h0, 0, 8'h00, 0, 1, 4'hF, 4'hF, 4'h0, 0, 1);
    add(4'h8, 0, 8'h00, 0, 4, 4'hF, 4'hF, 4'h0, 0, 1);
    n_phase_a = tbl.size();
    // after async reset with ch3 held pressed
    add(4'h7, 0, 8'h00, 0, 5, 4'h0, 4'h0, 4'h0, 0, 0);
    add(4'h7, 0, 8'h00, 0, 1, 4'h8, 4'h8, 4'h0, 0, 0);
    add(4'h7, 0, 8'h00, 0, 1, 4'h8, 4'h8, 4'h0, 0, 1);

    // reset is asserted from time 0, with no clock edge needed
    #1;
    check("reset_state", 14'h0);
    @(posedge clk);
    #1;
    check("reset_held", 14'h0);
    rst_n = 1'b1;

    for (int idx = 0; idx < n_phase_a; idx++) run_vec(idx);

    // asynchronous reset between edges while ch3 is mid-debounce and flags are set
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 14'h0);
    buttons = 4'h7;
    #1;
    rst_n = 1'b1;

    for (int idx = n_phase_a; idx < tbl.size(); idx++) run_vec(idx);

    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/button_input_capture.md
Name: button_input_capture

Overview:
- Input-side counterpart to the LED output path. Board push-buttons come into the SoC through this block.
- Per-channel 2-flop synchronisation, counter-based debounce, and sticky press/release event flags.
- An interrupt line and a pulse-driven clear interface are exposed to the SoC module.
- Sits in the board top level between the pins and the SoC status/IRQ inputs.

Parameters:
- CHANNELS, 4, number of button inputs (1..8).
- DEBOUNCE_CYCLES, 1000, consecutive stable cycles required to accept a level change (>=2).
- ACTIVE_LOW_INPUTS, 1, 1 = pin low means pressed; 0 = pin high means pressed.

Ports:
- Clock  input  1  system clock.
- Reset  input  1  asynchronous, active-low reset.
- Buttons  input  CHANNELS  raw button pins, asynchronous to Clock.
- IrqEnable  input  2*CHANNELS  per-flag interrupt enable, {release[CHANNELS-1:0], press[CHANNELS-1:0]}.
- ClearValid  input  1  single-cycle clear strobe.
- ClearMask  input  2*CHANNELS  flags to clear when ClearValid=1, same layout as IrqEnable.
- ClearOverrun  input  1  clears Overrun when ClearValid=1.
- Stable  output  CHANNELS  debounced pressed state, 1 = pressed.
- PressFlags  output  CHANNELS  sticky press events.
- ReleaseFlags  output  CHANNELS  sticky release events.
- Overrun  output  1  sticky: an event occurred while its flag was already set.
- Irq  output  1  registered interrupt request.

Behaviour:
- Reset is asynchronous, active-low (Reset=0 resets). While in reset, all state is cleared immediately without a clock edge:
  - sync flops load the not-pressed level;
  - debounce counters = 0;
  - Stable = 0, PressFlags = 0, ReleaseFlags = 0, Overrun = 0, Irq = 0.
- Reset asserted mid-debounce discards the partial count. No event is generated on reset release.
- Polarity: the pin is inverted when ACTIVE_LOW_INPUTS=1, then passes through two flops (sync1, sync2). Internal level p = sync2, where 1 = pressed.
- Debounce, per channel, counter width = clog2(DEBOUNCE_CYCLES):
  - If p == Stable: counter <= 0.
  - If p != Stable and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - If p != Stable and counter == DEBOUNCE_CYCLES-1: Stable <= p, counter <= 0.
  - Net effect: Stable changes on the DEBOUNCE_CYCLES-th consecutive edge on which p differs from Stable.
  - Any single-cycle return of p to Stable restarts the count. The counter never wraps.
- Latency: a clean pin change at cycle 0 appears on Stable at cycle 2+DEBOUNCE_CYCLES.
- Events: on the edge where Stable goes 0->1, PressFlags[i] <= 1. On the edge where Stable goes 1->0, ReleaseFlags[i] <= 1. Flags are visible in the same cycle as the new Stable value.
- Clear: when ClearValid=1, every flag whose ClearMask bit is 1 is cleared on that edge. Overrun is cleared if ClearOverrun=1. ClearMask and ClearOverrun are ignored when ClearValid=0.
- Simultaneous set and clear of the same flag on the same edge: set wins, so the flag stays 1 and no event is lost.
- Overrun: an event on a flag that is already 1 (and not being cleared that cycle) sets Overrun. Overrun stays set until cleared explicitly. Set-wins also applies to Overrun.
- Irq: registered, Irq <= |({ReleaseFlags, PressFlags} & IrqEnable), evaluated on the current flag values. Irq therefore lags a flag change by 1 cycle, and falls 1 cycle after the clear edge.
- Channels are fully independent. Simultaneous events on several channels all set their flags on the same edge.

Test Plan (DEBOUNCE_CYCLES=4, CHANNELS=4, ACTIVE_LOW_INPUTS=1, IrqEnable=8'h0F):
- Clean press: Buttons 4'hF -> 4'hE at cycle 0, held -> Stable=4'h1 and PressFlags=4'h1 at cycle 6; Irq=1 at cycle 7. Then release to 4'hF -> Stable=0 and ReleaseFlags=4'h1 at cycle 6 after release; Irq unchanged (release not enabled).
- Bounce rejection: Buttons[1] toggles every 3 cycles for 30 cycles, then returns high -> Stable, flags and Irq remain 0 throughout.
- Clear and set-wins: with PressFlags=4'h1, pulse ClearValid with ClearMask=8'h01 -> flag 0 at next edge, Irq 0 one cycle later. Repeat with the clear on the exact edge of a new press -> PressFlags[0] stays 1.
- Overrun: two clean presses of ch2 without a clear -> Overrun=1 on the second press edge. ClearValid with ClearOverrun=1 and ClearMask=8'h04 -> Overrun=0, PressFlags=0.
- Async reset mid-operation: pull Reset=0 between clock edges while ch3 is at debounce count 2 with flags set -> all outputs 0 before the next edge. Release reset with Buttons held pressed -> Stable[3]=1 six cycles after release, PressFlags[3]=1.
- Multi-channel: Buttons 4'hF -> 4'h0 simultaneously -> Stable=4'hF, PressFlags=4'hF on the same edge (cycle 6); Irq=1 at cycle 7.
